// File: rtl/mdio_frame_engine.sv
// Clause 22 MDIO master: divides clk down to MDC, shifts one 64-bit management frame out on the shared line,
// and captures read data. Define MDIO_PREAMBLE_SUPPRESS_EN to drop the preamble on every frame after the first.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_IDLE    | waiting for a request, mdc low, line released
//   S_PRE     | 32 preamble ones
//   S_ST_ADDR | start, opcode, PHY address, register address (14 bits)
//   S_TA      | turnaround (driven 10 on writes, released on reads)
//   S_DATA    | 16 data bits, driven on writes, sampled on reads
//   S_FIN     | one-cycle completion: done, read_data/data_valid update
module mdio_frame_engine #(
    parameter int REF_CLK = 50,
    parameter int MDC_CLK = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mdc,
    inout  wire logic   mdio,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic        write_req,
    input  logic [15:0] write_data,
    input  logic        read_req,
    output logic [15:0] read_data,
    output logic        data_valid,
    output logic        done,
    output logic        busy
);

    localparam int DIV = (REF_CLK * 1000) / MDC_CLK;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF_M1 = CW'(DIV / 2 - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRE     = 3'd1;
    localparam logic [2:0] S_ST_ADDR = 3'd2;
    localparam logic [2:0] S_TA      = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    generate
        if ((DIV % 2) != 0 || DIV < 4 || ((REF_CLK * 1000) % MDC_CLK) != 0) begin : g_bad_div
            $error("mdio_frame_engine: REF_CLK*1000/MDC_CLK must be an exact even divider >= 4");
        end
    endgenerate

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [5:0]    bit_cnt;
    logic [63:0]   frame_sr;
    logic [15:0]   rx_sr;
    logic          oe;
    logic          is_read;
    logic          accept;
    logic [63:0]   frame_word;
    logic [1:0]    op_bits;
    logic [1:0]    ta_bits;
    logic [15:0]   payload;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic          pre_sent;
`endif

    assign accept = (state == S_IDLE) && (write_req || read_req);

    // Write wins a simultaneous request; read frames carry filler that is never driven past ADDR.
    assign op_bits    = write_req ? 2'b01 : 2'b10;
    assign ta_bits    = write_req ? 2'b10 : 2'b11;
    assign payload    = write_req ? write_data : 16'h0000;
    assign frame_word = {32'hFFFF_FFFF, 2'b01, op_bits, phy_addr, reg_addr, ta_bits, payload};

    // The line only ever shows the MSB of the shift register, which moves on the mdc falling edge.
    assign mdio = oe ? frame_sr[63] : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            frame_sr   <= '0;
            rx_sr      <= '0;
            oe         <= 1'b0;
            is_read    <= 1'b0;
            read_data  <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            mdc        <= 1'b0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
            pre_sent   <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    mdc <= 1'b0;
                    if (accept) begin
                        busy     <= 1'b1;
                        oe       <= 1'b1;
                        is_read  <= ~write_req;
                        rx_sr    <= '0;
                        state    <= S_PRE;
                        bit_cnt  <= 6'd0;
                        frame_sr <= frame_word;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                        pre_sent <= 1'b1;
                        if (pre_sent) begin
                            state    <= S_ST_ADDR;
                            bit_cnt  <= 6'd32;
                            frame_sr <= {frame_word[31:0], 32'h0000_0000};
                        end
`endif
                    end
                end

                S_PRE, S_ST_ADDR, S_TA, S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end

                    // This edge raises mdc, so the PHY's read bit is captured right at the rising edge.
                    if (cnt == CNT_HALF_M1) begin
                        mdc <= 1'b1;
                        if (state == S_DATA) begin
                            rx_sr <= {rx_sr[14:0], mdio};
                        end
                    end

                    if (cnt == CNT_LAST) begin
                        mdc      <= 1'b0;
                        frame_sr <= {frame_sr[62:0], 1'b0};
                        bit_cnt  <= bit_cnt + 6'd1;
                        case (state)
                            S_PRE: begin
                                if (bit_cnt == 6'd31) begin
                                    state <= S_ST_ADDR;
                                end
                            end
                            S_ST_ADDR: begin
                                if (bit_cnt == 6'd45) begin
                                    state <= S_TA;
                                    if (is_read) begin
                                        oe <= 1'b0;
                                    end
                                end
                            end
                            S_TA: begin
                                if (bit_cnt == 6'd47) begin
                                    state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                if (bit_cnt == 6'd63) begin
                                    state <= S_FIN;
                                    oe    <= 1'b0;
                                    done  <= 1'b1;
                                    if (is_read) begin
                                        read_data  <= rx_sr;
                                        data_valid <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_FIN: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    mdc   <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    oe    <= 1'b0;
                    mdc   <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_frame_engine.sv
// Bench for mdio_frame_engine: table of transactions plus random ones, checked against a bit-level
// model of the Clause 22 frame, with a small PHY model answering reads on the pulled-up line.
module tb_mdio_frame_engine;

    localparam int DIV = 100;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam bit SUPP = 1'b1;
`else
    localparam bit SUPP = 1'b0;
`endif

    typedef bit bitq_t[$];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        logic [15:0] phy_rd;
        bit          mid_req;
        bit          exp_dv;
        logic [15:0] exp_rd;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        mdc;
    wire         mdio;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic        write_req;
    logic [15:0] write_data;
    logic        read_req;
    logic [15:0] read_data;
    logic        data_valid;
    logic        done;
    logic        busy;

    logic        phy_oe;
    logic        phy_out;

    pullup pu_mdio (mdio);
    assign mdio = phy_oe ? phy_out : 1'bz;

    mdio_frame_engine #(.REF_CLK(50), .MDC_CLK(500)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mdc        (mdc),
        .mdio       (mdio),
        .phy_addr   (phy_addr),
        .reg_addr   (reg_addr),
        .write_req  (write_req),
        .write_data (write_data),
        .read_req   (read_req),
        .read_data  (read_data),
        .data_valid (data_valid),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    bit          got[$];
    int          rises[$];
    int          falls[$];
    int          done_cnt = 0;
    int          dv_cnt = 0;
    int          edge_bad = 0;
    int          frame_start = 0;
    int          got_base = 0;
    bit          cur_read = 1'b0;
    logic [15:0] cur_rdata = 16'h0;
    bit          chk_edges = 1'b0;
    bit          first_frame = 1'b1;
    logic        prev_mdc = 1'b0;
    logic        prev_mdio = 1'b1;
    logic        prev_busy = 1'b0;

    initial begin
        phy_oe  = 1'b0;
        phy_out = 1'b0;
    end

    // PHY model: on each mdc rise, present the next frame bit it owns shortly afterwards.
    always @(posedge mdc) begin
        int k;
        got.push_back(mdio);
        k = frame_start + (got.size() - got_base);
        #1;
        if (cur_read && k == 47) begin
            phy_out = 1'b0;
            phy_oe  = 1'b1;
        end else if (cur_read && k >= 48 && k <= 63) begin
            phy_out = cur_rdata[63 - k];
            phy_oe  = 1'b1;
        end else begin
            phy_oe = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (data_valid) dv_cnt <= dv_cnt + 1;
        if (mdc && !prev_mdc) rises.push_back(cyc);
        if (!mdc && prev_mdc) falls.push_back(cyc);
        if (chk_edges && (mdio !== prev_mdio) && !((!mdc && prev_mdc) || !prev_busy))
            edge_bad <= edge_bad + 1;
        prev_mdc  <= mdc;
        prev_mdio <= mdio;
        prev_busy <= busy;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame as seen on the wire at each mdc rise; read TA shows pull-up 1 then PHY 0.
    function automatic bitq_t exp_frame(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                                        input logic [15:0] wd, input logic [15:0] rd, input int start);
        bitq_t       q;
        logic [15:0] pl;
        pl = wr ? wd : rd;
        for (int i = 0; i < 32; i++) q.push_back(1'b1);
        q.push_back(1'b0);
        q.push_back(1'b1);
        if (wr) begin
            q.push_back(1'b0);
            q.push_back(1'b1);
        end else begin
            q.push_back(1'b1);
            q.push_back(1'b0);
        end
        for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
        for (int i = 4; i >= 0; i--) q.push_back(rg[i]);
        q.push_back(1'b1);
        q.push_back(1'b0);
        for (int i = 15; i >= 0; i--) q.push_back(pl[i]);
        for (int i = 0; i < start; i++) void'(q.pop_front());
        return q;
    endfunction

    task automatic run_vec(input vec_t v);
        bitq_t exp_q;
        int    start, nbits, acc, waited, done_base, dv_base, edge_base, rise_base, fall_base;
        int    nbad, first_bad, tbad, busy_seen;
        start = (SUPP && !first_frame) ? 32 : 0;
        nbits = 64 - start;
        exp_q = exp_frame(v.wr, v.phy, v.rg, v.wd, v.phy_rd, start);

        frame_start = start;
        got_base    = got.size();
        cur_read    = !v.wr && v.rd;
        cur_rdata   = v.phy_rd;
        chk_edges   = v.wr;
        done_base   = done_cnt;
        dv_base     = dv_cnt;
        edge_base   = edge_bad;
        rise_base   = rises.size();
        fall_base   = falls.size();

        phy_addr   = v.phy;
        reg_addr   = v.rg;
        write_data = v.wd;
        write_req  = v.wr;
        read_req   = v.rd;
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        write_req = 1'b0;
        read_req  = 1'b0;
        phy_addr  = 5'($urandom);
        reg_addr  = 5'($urandom);
        write_data = 16'($urandom);
        first_frame = 1'b0;
        chk("busy_after_accept", busy, 1'b1);

        waited = 0;
        while (!done && waited < 70 * DIV) begin
            if (v.mid_req && waited == 1000) read_req = 1'b1;
            if (v.mid_req && waited == 1001) read_req = 1'b0;
            @(negedge clk);
            waited++;
        end
        read_req = 1'b0;
        chk("done_seen", done, 1'b1);
        chk("latency", cyc - acc, nbits * DIV);
        chk("data_valid_at_done", data_valid, v.exp_dv);
        chk("read_data", read_data, v.exp_rd);
        chk("busy_in_fin", busy, 1'b1);

        @(negedge clk);
        chk("busy_after_fin", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        chk("mdc_idle", mdc, 1'b0);
        chk("mdio_released_idle", mdio, 1'b1);

        if (v.mid_req) begin
            busy_seen = 0;
            repeat (2 * DIV) begin
                @(negedge clk);
                if (busy) busy_seen++;
            end
            chk("midreq_ignored", busy_seen, 0);
        end
        chk("done_pulses", done_cnt - done_base, 1);
        chk("dv_pulses", dv_cnt - dv_base, v.exp_dv ? 1 : 0);
        chk_edges = 1'b0;
        if (v.wr) chk("mdio_edges_on_mdc_fall", edge_bad - edge_base, 0);

        chk("frame_len", got.size() - got_base, exp_q.size());
        nbad = 0;
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && (got_base + i) < got.size(); i++) begin
            if (got[got_base + i] !== exp_q[i]) begin
                nbad++;
                if (first_bad < 0) first_bad = i + start;
            end
        end
        if (nbad != 0) $display("first differing frame bit index %0d", first_bad);
        chk("frame_bits", nbad, 0);

        tbad = 0;
        if (rises.size() - rise_base != nbits || falls.size() - fall_base != nbits) tbad++;
        else begin
            if (rises[rise_base] - acc != DIV / 2) tbad++;
            for (int i = 0; i < nbits; i++) begin
                if (falls[fall_base + i] - rises[rise_base + i] != DIV / 2) tbad++;
                if (i > 0 && rises[rise_base + i] - rises[rise_base + i - 1] != DIV) tbad++;
            end
        end
        chk("mdc_timing", tbad, 0);
    endtask

    task automatic reset_abort();
        int gb, w, done_base, dv_base;
        frame_start = (SUPP && !first_frame) ? 32 : 0;
        gb          = got.size();
        got_base    = gb;
        cur_read    = 1'b1;
        cur_rdata   = 16'hFFFF;
        done_base   = done_cnt;
        dv_base     = dv_cnt;
        phy_addr    = 5'h0A;
        reg_addr    = 5'h03;
        read_req    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read_req    = 1'b0;
        first_frame = 1'b0;
        w = 0;
        while ((frame_start + got.size() - gb) < 41 && w < 70 * DIV) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reached_bit40", (frame_start + got.size() - gb) >= 41, 1'b1);
        chk("mdio_bit40_driven", mdio, 1'b0);
        chk("busy_before_abort", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_mdc", mdc, 1'b0);
        chk("abort_mdio_released", mdio, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_read_data", read_data, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("abort_no_done", done_cnt - done_base, 0);
        chk("abort_no_dv", dv_cnt - dv_base, 0);
        chk("abort_stays_idle", busy, 1'b0);
        cur_read    = 1'b0;
        first_frame = 1'b1;
    endtask

    localparam int NV = 5;
    vec_t        vecs[NV];
    vec_t        post;
    logic [15:0] prev_rd;

    initial begin
        vecs[0] = '{wr: 1'b1, rd: 1'b0, phy: 5'h01, rg: 5'h00, wd: 16'h1340, phy_rd: 16'h0000,
                    mid_req: 1'b0, exp_dv: 1'b0, exp_rd: 16'h0};
        vecs[1] = '{wr: 1'b0, rd: 1'b1, phy: 5'h01, rg: 5'h11, wd: 16'h0000, phy_rd: 16'hAC00,
                    mid_req: 1'b0, exp_dv: 1'b0, exp_rd: 16'h0};
        vecs[2] = '{wr: 1'b1, rd: 1'b1, phy: 5'h1F, rg: 5'h15, wd: 16'h5A3C, phy_rd: 16'h9999,
                    mid_req: 1'b1, exp_dv: 1'b0, exp_rd: 16'h0};
        for (int i = 3; i < NV; i++) begin
            vecs[i].wr      = 1'($urandom_range(0, 1));
            vecs[i].rd      = !vecs[i].wr || 1'($urandom_range(0, 1));
            vecs[i].phy     = 5'($urandom);
            vecs[i].rg      = 5'($urandom);
            vecs[i].wd      = 16'($urandom);
            vecs[i].phy_rd  = 16'($urandom);
            vecs[i].mid_req = 1'b0;
        end
        prev_rd = 16'h0;
        for (int i = 0; i < NV; i++) begin
            vecs[i].exp_dv = !vecs[i].wr;
            vecs[i].exp_rd = vecs[i].exp_dv ? vecs[i].phy_rd : prev_rd;
            prev_rd        = vecs[i].exp_rd;
        end
        post = '{wr: 1'b0, rd: 1'b1, phy: 5'($urandom), rg: 5'($urandom), wd: 16'h0,
                 phy_rd: 16'($urandom), mid_req: 1'b0, exp_dv: 1'b1, exp_rd: 16'h0};
        post.exp_rd = post.phy_rd;

        rst_n      = 1'b0;
        write_req  = 1'b0;
        read_req   = 1'b0;
        phy_addr   = 5'h0;
        reg_addr   = 5'h0;
        write_data = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_mdc", mdc, 1'b0);
        chk("rst_mdio_released", mdio, 1'b1);
        chk("rst_read_data", read_data, 16'h0);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_mdc", mdc, 1'b0);
        chk("idle_busy", busy, 1'b0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);
        reset_abort();
        run_vec(post);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_frame_engine.md
Name: mdio_frame_engine

Overview:
- Serial MDIO (IEEE 802.3 Clause 22) master engine that sits directly below the PHY configuration/link-poll controller.
- Accepts single-cycle read or write requests with PHY address, register address and write data.
- Generates MDC from clk, serialises the 64-bit management frame on the tristate MDIO line, captures read data, and reports completion.

Parameters:
- REF_CLK, 50, clk frequency in MHz
- MDC_CLK, 500, MDC frequency in kHz. DIV = REF_CLK*1000/MDC_CLK (100 at defaults). DIV must be even and >= 4; anything else is a configuration error, flagged by an elaboration-time check.

Ports:
- clk  input  1  system clock, REF_CLK MHz
- rst_n  input  1  reset
- mdc  output  1  management clock to PHY
- mdio  inout  1  management data; driven or released (Z)
- phy_addr  input  5  PHY address, sampled at request accept
- reg_addr  input  5  register address, sampled at request accept
- write_req  input  1  single-cycle write request
- write_data  input  16  write payload, sampled at request accept
- read_req  input  1  single-cycle read request
- read_data  output  16  last captured read value
- data_valid  output  1  one-cycle pulse, read_data updated
- done  output  1  one-cycle pulse, transaction finished
- busy  output  1  transaction in progress

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset: mdc=0, MDIO released (Z), read_data=0, data_valid=0, done=0, busy=0, state=IDLE, all counters 0. Reset mid-frame aborts immediately with no done pulse.
- Request accept:
  - Requests are accepted only in IDLE.
  - If write_req and read_req are both high in the same cycle, write wins and the read is dropped.
  - Requests while busy are ignored (not queued).
  - On accept, phy_addr, reg_addr, write_data and the opcode are latched; busy=1 from the next cycle.
- MDC generation:
  - The divider counter cnt runs 0..DIV-1 only while busy; mdc=0 when idle.
  - mdc=0 for cnt<DIV/2 and mdc=1 for cnt>=DIV/2.
  - Drive tick at cnt==0: MDIO output changes only here, so it is stable at the MDC rising edge.
  - Sample tick at cnt==DIV/2: this is the MDC rising edge.
- Frame: 64 bits, one bit per MDC period, bit counter 0..63, MSB first:
  - PRE, 32 bits: all 1.
  - ST, 2 bits: 01.
  - OP, 2 bits: 01 for write, 10 for read.
  - PHYAD, 5 bits; then REGAD, 5 bits.
  - TA, 2 bits: write drives 10; read releases MDIO from the first TA bit.
  - DATA, 16 bits: write drives write_data[15:0]; read keeps MDIO released and samples at each sample tick, MSB first, into a shift register.
- State machine:
  - IDLE -> PRE on accepted request.
  - PRE -> ST_ADDR after bit 31.
  - ST_ADDR (14 bits) -> TA.
  - TA (2 bits) -> DATA.
  - DATA -> FIN after bit 63 completes (cnt==DIV-1).
  - FIN -> IDLE in one cycle.
- Completion:
  - In FIN: done=1 for one cycle, busy drops next cycle, MDIO released, mdc=0.
  - For reads, in the same FIN cycle: read_data <= shift register and data_valid=1.
  - Writes never pulse data_valid and never change read_data.
- Latency: request at cycle N; first drive tick at N+1; done at N+1+64*DIV (6401 cycles at defaults). A new request is accepted the cycle after busy falls.
- MDIO output enable: asserted from PRE through the TA/DATA region for writes; for reads, deasserted from TA onward. There is no TA check on reads (PHY TA=0 is not verified).

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: the first frame after reset sends the full 32-bit preamble; every later frame skips PRE and starts at ST. Frame is 32 bits; done at N+1+32*DIV.
- Not defined: every frame carries the 32-bit preamble.

Test Plan:
- Write phy=0x01 reg=0x00 data=0x1340 -> MDIO bit stream 32x1, 01 01 00001 00000 10 0001001101000000, sampled at MDC rises; done pulse 1 cycle at N+6401; data_valid stays 0.
- Read phy=0x01 reg=0x11, PHY model drives 0xAC00 after TA -> MDIO released from bit 46; read_data=0xAC00, data_valid and done high in the same cycle.
- MDC check at defaults -> period 100 clk, 50 high/50 low; mdc=0 while idle; MDIO transitions only at the start of the mdc-low half.
- read_req and write_req in the same cycle, then read_req pulsed mid-frame -> only the write frame occurs (OP=01); mid-frame request ignored; exactly one done.
- rst_n asserted at bit 40 of a read -> mdc=0, MDIO=Z, busy=0 immediately; no done; next read completes normally.
- With MDIO_PREAMBLE_SUPPRESS_EN, two reads back-to-back -> first frame 64 bits, second 32 bits; done at N+1+32*DIV.
